// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, bit-reversal helper and read-FSM state for the 512-point FFT tail.
package fft_pkg;
    localparam int FFT_N     = 512;
    localparam int FFT_PAR   = 16;
    localparam int FFT_LOG2N = 9;
    localparam int FFT_BEATS = 32;

    typedef enum logic {S_IDLE, S_READ} reorder_state_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev9(input logic [FFT_LOG2N-1:0] x);
        logic [FFT_LOG2N-1:0] r;
        for (int b = 0; b < FFT_LOG2N; b++) r[b] = x[FFT_LOG2N-1-b];
        return r;
    endfunction
endpackage

// File: rtl/reorder_bank.sv
// reorder_bank: one 512-entry complex frame store, written a beat at a time and
// read back as a bit-reversed gather of natural-order bins.
module reorder_bank
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 13
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(FFT_BEATS)-1:0] wr_addr,
    input  logic signed [DATA_WIDTH-1:0] wr_i [0:FFT_PAR-1],
    input  logic signed [DATA_WIDTH-1:0] wr_q [0:FFT_PAR-1],
    input  logic [$clog2(FFT_BEATS)-1:0] rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_i [0:FFT_PAR-1],
    output logic signed [DATA_WIDTH-1:0] rd_q [0:FFT_PAR-1]
);
    logic signed [DATA_WIDTH-1:0] mem_i [0:FFT_N-1];
    logic signed [DATA_WIDTH-1:0] mem_q [0:FFT_N-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < FFT_PAR; k++) begin
                mem_i[{wr_addr, k[3:0]}] <= wr_i[k];
                mem_q[{wr_addr, k[3:0]}] <= wr_q[k];
            end
        end
    end

    // Bin n = {rd_addr, lane} sits at frame position bitrev9(n).
    always_comb begin
        for (int j = 0; j < FFT_PAR; j++) begin
            rd_i[j] = mem_i[bitrev9({rd_addr, j[3:0]})];
            rd_q[j] = mem_q[bitrev9({rd_addr, j[3:0]})];
        end
    end
endmodule

// File: rtl/fft_reorder_out.sv
// fft_reorder_out: ping-pong reorder of bit-reversed FFT frames into natural order.
// Define FFT_REORDER_SOF_EN to add the dout_sof start-of-frame output.
module fft_reorder_out
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 13,
    parameter int N          = FFT_N,
    parameter int PAR        = FFT_PAR
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         din_valid,
    input  logic signed [DATA_WIDTH-1:0] din_i [0:PAR-1],
    input  logic signed [DATA_WIDTH-1:0] din_q [0:PAR-1],
    output logic signed [DATA_WIDTH-1:0] dout_i [0:PAR-1],
    output logic signed [DATA_WIDTH-1:0] dout_q [0:PAR-1],
`ifdef FFT_REORDER_SOF_EN
    output logic                         dout_sof,
`endif
    output logic                         dout_valid
);
    localparam int AW = $clog2(N / PAR);

    logic [AW-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic           wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic           frame_rdy_q, frame_rdy_d, dout_valid_q, dout_valid_d;
    logic           wr_last, rd_last, wr_en;
    reorder_state_t state_q, state_d;
    logic signed [DATA_WIDTH-1:0] b0_i [0:PAR-1], b0_q [0:PAR-1];
    logic signed [DATA_WIDTH-1:0] b1_i [0:PAR-1], b1_q [0:PAR-1];
    logic signed [DATA_WIDTH-1:0] dout_i_q [0:PAR-1], dout_i_d [0:PAR-1];
    logic signed [DATA_WIDTH-1:0] dout_q_q [0:PAR-1], dout_q_d [0:PAR-1];
`ifdef FFT_REORDER_SOF_EN
    logic           sof_q, sof_d;
`endif

    assign wr_en = din_valid && !rst;

    reorder_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank0 (
        .clk(clk), .we(wr_en && !wr_bank_q), .wr_addr(wr_cnt_q), .wr_i(din_i), .wr_q(din_q),
        .rd_addr(rd_cnt_q), .rd_i(b0_i), .rd_q(b0_q)
    );

    reorder_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank1 (
        .clk(clk), .we(wr_en && wr_bank_q), .wr_addr(wr_cnt_q), .wr_i(din_i), .wr_q(din_q),
        .rd_addr(rd_cnt_q), .rd_i(b1_i), .rd_q(b1_q)
    );

    // The completed bank is the one just left: wr_bank_q has already toggled.
    always_comb begin
        wr_last      = din_valid && (wr_cnt_q == AW'(FFT_BEATS - 1));
        rd_last      = (state_q == S_READ) && (rd_cnt_q == AW'(FFT_BEATS - 1));
        wr_cnt_d     = din_valid ? wr_cnt_q + 1'b1 : wr_cnt_q;
        wr_bank_d    = wr_bank_q ^ wr_last;
        frame_rdy_d  = wr_last;
        state_d      = frame_rdy_q ? S_READ : rd_last ? S_IDLE : state_q;
        rd_cnt_d     = frame_rdy_q ? '0 : (state_q == S_READ) ? rd_cnt_q + 1'b1 : rd_cnt_q;
        rd_bank_d    = frame_rdy_q ? ~wr_bank_q : rd_bank_q;
        dout_valid_d = state_q == S_READ;
        for (int k = 0; k < PAR; k++) begin
            dout_i_d[k] = rd_bank_q ? b1_i[k] : b0_i[k];
            dout_q_d[k] = rd_bank_q ? b1_q[k] : b0_q[k];
        end
`ifdef FFT_REORDER_SOF_EN
        sof_d        = (state_q == S_READ) && (rd_cnt_q == '0);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q     <= '0;
            wr_bank_q    <= 1'b0;
            frame_rdy_q  <= 1'b0;
            state_q      <= S_IDLE;
            rd_cnt_q     <= '0;
            rd_bank_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            for (int k = 0; k < PAR; k++) begin
                dout_i_q[k] <= '0;
                dout_q_q[k] <= '0;
            end
`ifdef FFT_REORDER_SOF_EN
            sof_q        <= 1'b0;
`endif
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            wr_bank_q    <= wr_bank_d;
            frame_rdy_q  <= frame_rdy_d;
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_bank_q    <= rd_bank_d;
            dout_valid_q <= dout_valid_d;
            dout_i_q     <= dout_i_d;
            dout_q_q     <= dout_q_d;
`ifdef FFT_REORDER_SOF_EN
            sof_q        <= sof_d;
`endif
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout_i     = dout_i_q;
    assign dout_q     = dout_q_q;
`ifdef FFT_REORDER_SOF_EN
    assign dout_sof   = sof_q;
`endif
endmodule

// File: tb/tb_fft_reorder_out.sv
// tb_fft_reorder_out: directed checks of reorder order, latency, ping-pong, gaps,
// resets and (with FFT_REORDER_SOF_EN) dout_sof.
`timescale 1ns/1ps
module tb_fft_reorder_out;
    localparam int W = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din_valid = 1'b0;
    logic dout_valid;
    logic signed [W-1:0] din_i [0:15];
    logic signed [W-1:0] din_q [0:15];
    logic signed [W-1:0] dout_i [0:15];
    logic signed [W-1:0] dout_q [0:15];
`ifdef FFT_REORDER_SOF_EN
    logic dout_sof;
    logic cap_sof [0:127];
    int   sof_n = 0;
`endif

    int n_vec = 0, n_err = 0, cyc = 0, cap_n = 0, last_e = 0, e1 = 0, e2 = 0;
    int cap_cyc [0:127];
    int cap_i [0:127][0:15];
    int cap_q [0:127][0:15];

    fft_reorder_out #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_i(din_i), .din_q(din_q),
        .dout_i(dout_i), .dout_q(dout_q),
`ifdef FFT_REORDER_SOF_EN
        .dout_sof(dout_sof),
`endif
        .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_valid) begin
            if (cap_n < 128) begin
                cap_cyc[cap_n] = cyc;
                for (int j = 0; j < 16; j++) begin
                    cap_i[cap_n][j] = int'(dout_i[j]);
                    cap_q[cap_n][j] = int'(dout_q[j]);
                end
`ifdef FFT_REORDER_SOF_EN
                cap_sof[cap_n] = dout_sof;
`endif
            end
            cap_n++;
        end
`ifdef FFT_REORDER_SOF_EN
        if (dout_sof) sof_n++;
`endif
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rev(input int x, input int bits);
        int r;
        r = 0;
        for (int b = 0; b < bits; b++) r = (r << 1) | ((x >> b) & 1);
        return r;
    endfunction

    task automatic send_beat(input int c, input int base);
        din_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            din_i[k] = W'(base + 16 * c + k);
            din_q[k] = W'(-(base + 16 * c + k));
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        last_e = cyc;
    endtask

    task automatic send_frame(input int base, input bit gap);
        for (int c = 0; c < 32; c++) begin
            send_beat(c, base);
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected bin source: beat 2*rev4(j) + rev5(m)/16, lane rev5(m)%16.
    task automatic check_frame(input string tag, input int idx, input int base, input int e);
        int p;
        check({tag, " first beat edge"}, cap_cyc[idx], e + 2);
        check({tag, " last beat edge"}, cap_cyc[idx + 31], e + 33);
        for (int m = 0; m < 32; m++) begin
            for (int j = 0; j < 16; j++) begin
                p = 16 * (2 * rev(j, 4) + (rev(m, 5) >> 4)) + (rev(m, 5) & 15);
                check($sformatf("%s i m%0d j%0d", tag, m, j), cap_i[idx + m][j], base + p);
                check($sformatf("%s q m%0d j%0d", tag, m, j), cap_q[idx + m][j], -(base + p));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            din_i[k] = '0;
            din_q[k] = '0;
        end
        idle(3);
        check("reset dout_valid", int'(dout_valid), 0);
        check("reset dout_i0", int'(dout_i[0]), 0);
        check("reset dout_q15", int'(dout_q[15]), 0);
`ifdef FFT_REORDER_SOF_EN
        check("reset dout_sof", int'(dout_sof), 0);
`endif
        rst = 1'b0;
        idle(2);

        cap_n = 0;
        send_frame(0, 1'b0);
        idle(45);
        check("ramp beats", cap_n, 32);
        check("ramp b0 l0 i", cap_i[0][0], 0);
        check("ramp b0 l1 i", cap_i[0][1], 256);
        check("ramp b0 l2 i", cap_i[0][2], 128);
        check("ramp b0 l3 i", cap_i[0][3], 384);
        check("ramp b1 l0 i", cap_i[1][0], 16);
        check("ramp b0 l1 q", cap_q[0][1], -256);
        check_frame("ramp", 0, 0, last_e);

        cap_n = 0;
`ifdef FFT_REORDER_SOF_EN
        sof_n = 0;
`endif
        send_frame(0, 1'b0);
        e1 = last_e;
        send_frame(1000, 1'b0);
        e2 = last_e;
        idle(45);
        check("b2b beats", cap_n, 64);
        check_frame("b2b f0", 0, 0, e1);
        check_frame("b2b f1", 32, 1000, e2);
`ifdef FFT_REORDER_SOF_EN
        check("sof count", sof_n, 2);
        check("sof f0 beat0", int'(cap_sof[0]), 1);
        check("sof f0 beat1", int'(cap_sof[1]), 0);
        check("sof f1 beat0", int'(cap_sof[32]), 1);
        check("sof f0 beat31", int'(cap_sof[31]), 0);
`endif

        cap_n = 0;
        send_frame(0, 1'b1);
        idle(45);
        check("gap beats", cap_n, 32);
        check_frame("gap", 0, 0, last_e);

        cap_n = 0;
        for (int c = 0; c < 10; c++) send_beat(c, 2000);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(40);
        check("partial frame beats", cap_n, 0);
        send_frame(0, 1'b0);
        idle(45);
        check("post-rst beats", cap_n, 32);
        check_frame("post-rst", 0, 0, last_e);

        cap_n = 0;
        send_frame(700, 1'b0);
        for (int t = 0; t < 60 && cap_n < 6; t++) begin
            @(negedge clk);
            #1;
        end
        check("readout beats before rst", cap_n, 6);
        check("readout b5 l0 i", cap_i[5][0], 720);
        rst = 1'b1;
        din_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            din_i[k] = W'(3000);
            din_q[k] = W'(-3000);
        end
        @(posedge clk);
        #1;
        check("valid on rst edge", int'(dout_valid), 0);
        rst = 1'b0;
        din_valid = 1'b0;
        idle(40);
        check("no output after rst", cap_n, 6);
        cap_n = 0;
        send_frame(500, 1'b0);
        idle(45);
        check("after readout rst beats", cap_n, 32);
        check_frame("after readout rst", 0, 500, last_e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
